// File: rtl/td4_pkg.sv
// Shared constants and types for the TD4 4-bit CPU: opcodes, operand selects,
// active-low load masks and the run-control state encoding.
package td4_pkg;

   localparam logic [3:0] OP_ADD_A_IM = 4'b0000;
   localparam logic [3:0] OP_MOV_A_B  = 4'b0001;
   localparam logic [3:0] OP_IN_A     = 4'b0010;
   localparam logic [3:0] OP_MOV_A_IM = 4'b0011;
   localparam logic [3:0] OP_MOV_B_A  = 4'b0100;
   localparam logic [3:0] OP_ADD_B_IM = 4'b0101;
   localparam logic [3:0] OP_IN_B     = 4'b0110;
   localparam logic [3:0] OP_MOV_B_IM = 4'b0111;
   localparam logic [3:0] OP_OUT_B    = 4'b1001;
   localparam logic [3:0] OP_OUT_IM   = 4'b1011;
   localparam logic [3:0] OP_JNC      = 4'b1110;
   localparam logic [3:0] OP_JMP      = 4'b1111;

   localparam logic [1:0] SEL_A    = 2'b00;
   localparam logic [1:0] SEL_B    = 2'b01;
   localparam logic [1:0] SEL_IN   = 2'b10;
   localparam logic [1:0] SEL_ZERO = 2'b11;

   // Load masks are active-low: a 0 bit selects the destination register.
   localparam logic [3:0] LD_A    = 4'b1110;
   localparam logic [3:0] LD_B    = 4'b1101;
   localparam logic [3:0] LD_OUT  = 4'b1011;
   localparam logic [3:0] LD_PC   = 4'b0111;
   localparam logic [3:0] LD_NONE = 4'b1111;

   typedef enum logic {HALT, RUN} run_state_e;

   // 4-bit add returning {carry, sum}.
   function automatic logic [4:0] td4_add(input logic [3:0] x, input logic [3:0] y);
      return {1'b0, x} + {1'b0, y};
   endfunction

endpackage

// File: rtl/td4_if.sv
// Decoder/ROM <-> execute-stage bus: instruction fetch, op/carry to the decoder,
// and the decoder's operand select and load strobes back.
interface td4_if;
   logic [3:0] pc;
   logic [7:0] rom_data;
   logic [3:0] op;
   logic       c;
   logic [1:0] sel;
   logic [3:0] ld;

   modport master (input pc, op, c, output rom_data, sel, ld);
   modport slave  (output pc, op, c, input rom_data, sel, ld);
endinterface

// File: rtl/td4_run_ctrl.sv
// Run/step controller: decides in which cycles an instruction commits, either at
// a divided clock rate while running or once per step rising edge while halted.
module td4_run_ctrl
   import td4_pkg::*;
#(
   parameter int unsigned CYCLE_DIV     = 1,
   parameter bit          START_RUNNING = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run_en_i,
   input  logic step_i,
   output logic exe_o,
   output logic running_o
);

   localparam int unsigned     DivW    = (CYCLE_DIV > 1) ? $clog2(CYCLE_DIV) : 1;
   localparam logic [DivW-1:0] DivLast = DivW'(CYCLE_DIV - 1);
   localparam run_state_e      StReset = START_RUNNING ? RUN : HALT;

   run_state_e      state_q, state_d;
   logic [DivW-1:0] div_q, div_d;
   logic            step_q;
   logic            step_rise;
   logic            exe;

   assign step_rise = step_i & ~step_q;

   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      exe     = 1'b0;
      unique case (state_q)
         HALT: begin
            // A step edge coinciding with the switch to RUN is swallowed.
            if (run_en_i) begin
               state_d = RUN;
               div_d   = '0;
            end else if (step_rise) begin
               exe = 1'b1;
            end
         end
         RUN: begin
            if (!run_en_i) begin
               state_d = HALT;
               div_d   = '0;
            end else if (div_q == DivLast) begin
               exe   = 1'b1;
               div_d = '0;
            end else begin
               div_d = div_q + DivW'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StReset;
         div_q   <= '0;
         step_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         step_q  <= step_i;
      end
   end

   // Forced low while reset is held so no commit can be reported mid-reset.
   assign exe_o     = exe & rst_n;
   assign running_o = (state_q == RUN);

endmodule

// File: rtl/td4_datapath.sv
// TD4 execute stage: architectural registers, operand mux, 4-bit adder and
// commit logic, gated by the run/step controller.
module td4_datapath
   import td4_pkg::*;
#(
   parameter int unsigned CYCLE_DIV     = 1,
   parameter bit          START_RUNNING = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       run_en_i,
   input  logic       step_i,
   input  logic [3:0] in_port_i,
   td4_if.slave       bus,
   output logic [3:0] out_port_o,
   output logic       exec_pulse_o,
   output logic       running_o
);

   logic [3:0] a_q, a_d;
   logic [3:0] b_q, b_d;
   logic [3:0] out_q, out_d;
   logic [3:0] pc_q, pc_d;
   logic       c_q, c_d;
   logic [3:0] imm;
   logic [3:0] mux;
   logic [4:0] sum5;
   logic       exe;

   td4_run_ctrl #(
      .CYCLE_DIV     (CYCLE_DIV),
      .START_RUNNING (START_RUNNING)
   ) u_run_ctrl (
      .clk       (clk),
      .rst_n     (rst_n),
      .run_en_i  (run_en_i),
      .step_i    (step_i),
      .exe_o     (exe),
      .running_o (running_o)
   );

   assign imm = bus.rom_data[3:0];

   always_comb begin
      mux = 4'h0;
      case (bus.sel)
         SEL_A:   mux = a_q;
         SEL_B:   mux = b_q;
         SEL_IN:  mux = in_port_i;
         default: mux = 4'h0;
      endcase
   end

   assign sum5 = td4_add(mux, imm);

   // Each test is written as ==1'b0 so an X load bit falls into hold/increment.
   always_comb begin
      a_d   = a_q;
      b_d   = b_q;
      out_d = out_q;
      pc_d  = pc_q;
      c_d   = c_q;
      if (exe) begin
         if (bus.ld[0] == 1'b0) a_d = sum5[3:0];
         if (bus.ld[1] == 1'b0) b_d = sum5[3:0];
         if (bus.ld[2] == 1'b0) out_d = sum5[3:0];
         if (bus.ld[3] == 1'b0) pc_d = sum5[3:0];
         else                   pc_d = pc_q + 4'd1;
         c_d = sum5[4];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q   <= 4'h0;
         b_q   <= 4'h0;
         out_q <= 4'h0;
         pc_q  <= 4'h0;
         c_q   <= 1'b0;
      end else begin
         a_q   <= a_d;
         b_q   <= b_d;
         out_q <= out_d;
         pc_q  <= pc_d;
         c_q   <= c_d;
      end
   end

   assign bus.pc       = pc_q;
   assign bus.c        = c_q;
   assign bus.op       = bus.rom_data[7:4];
   assign out_port_o   = out_q;
   assign exec_pulse_o = exe;

endmodule

// File: tb/tb_td4_datapath.sv
// Self-checking bench for td4_datapath: the bench plays decoder and ROM, and a
// scoreboard of expected architectural state is popped on every commit.
module tb_td4_datapath;
   import td4_pkg::*;

   localparam int unsigned CycleDiv = 4;

   typedef struct packed {
      logic [3:0] a;
      logic [3:0] b;
      logic [3:0] out;
      logic [3:0] pc;
      logic       c;
   } arch_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       run_en = 1'b0;
   logic       step = 1'b0;
   logic [3:0] in_port = 4'h0;
   logic [3:0] out_port;
   logic       exec_pulse;
   logic       running;

   arch_t sb_q[$];
   arch_t m;
   int    errors = 0;
   int    checks = 0;
   int    total_pulses = 0;

   td4_if bus ();

   td4_datapath #(
      .CYCLE_DIV     (CycleDiv),
      .START_RUNNING (1'b0)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .run_en_i     (run_en),
      .step_i       (step),
      .in_port_i    (in_port),
      .bus          (bus),
      .out_port_o   (out_port),
      .exec_pulse_o (exec_pulse),
      .running_o    (running)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish by %0t, required finish earlier", $time);
      $fatal(1);
   end

   function automatic arch_t model_commit(arch_t s, logic [1:0] sel, logic [3:0] ld,
                                          logic [3:0] imm, logic [3:0] inp);
      logic [3:0] opnd;
      logic [4:0] r;
      arch_t      n;
      n = s;
      case (sel)
         2'b00:   opnd = s.a;
         2'b01:   opnd = s.b;
         2'b10:   opnd = inp;
         default: opnd = 4'h0;
      endcase
      r = {1'b0, opnd} + {1'b0, imm};
      if (ld[0] === 1'b0) n.a = r[3:0];
      if (ld[1] === 1'b0) n.b = r[3:0];
      if (ld[2] === 1'b0) n.out = r[3:0];
      if (ld[3] === 1'b0) n.pc = r[3:0];
      else                n.pc = s.pc + 4'd1;
      n.c = r[4];
      return n;
   endfunction

   function automatic arch_t actual();
      arch_t g;
      g.a   = dut.a_q;
      g.b   = dut.b_q;
      g.out = out_port;
      g.pc  = bus.pc;
      g.c   = bus.c;
      return g;
   endfunction

   // Present one instruction and push the expected state of n commits of it.
   task automatic queue_instr(input logic [3:0] op, input logic [1:0] sel,
                              input logic [3:0] ld, input logic [3:0] imm, input int n);
      bus.rom_data = {op, imm};
      bus.sel      = sel;
      bus.ld       = ld;
      for (int i = 0; i < n; i++) begin
         m = model_commit(m, sel, ld, imm, in_port);
         sb_q.push_back(m);
      end
   endtask

   // Runs ncyc cycles; every commit pops the scoreboard and compares state.
   task automatic observe(input int ncyc, input bit toggle, output int pulses);
      arch_t exp_s;
      arch_t got_s;
      pulses = 0;
      for (int i = 0; i < ncyc; i++) begin
         @(negedge clk);
         if (exec_pulse === 1'b1) begin
            pulses++;
            @(posedge clk);
            #1;
            checks++;
            if (sb_q.size() == 0) begin
               errors++;
               $display("FAIL commit_unexpected: got commit at %0t, required none", $time);
            end else begin
               exp_s = sb_q.pop_front();
               got_s = actual();
               if (got_s !== exp_s) begin
                  errors++;
                  $display("FAIL commit_state: got a=%h b=%h out=%h pc=%h c=%b, required a=%h b=%h out=%h pc=%h c=%b",
                           got_s.a, got_s.b, got_s.out, got_s.pc, got_s.c,
                           exp_s.a, exp_s.b, exp_s.out, exp_s.pc, exp_s.c);
               end
            end
         end else begin
            @(posedge clk);
            #1;
         end
         if (toggle) step = ~step;
      end
   endtask

   task automatic do_step(input logic [3:0] op, input logic [1:0] sel,
                          input logic [3:0] ld, input logic [3:0] imm);
      int p;
      queue_instr(op, sel, ld, imm, 1);
      step = 1'b1;
      observe(1, 1'b0, p);
      step = 1'b0;
      @(posedge clk);
      #1;
      total_pulses += p;
   endtask

   task automatic check_drained(input string name);
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL %s_pending: got %0d commits missing, required 0", name, sb_q.size());
      end
      sb_q.delete();
   endtask

   task automatic test_reset();
      int p;
      checks++;
      if (actual() !== arch_t'(0) || running !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: got %h run=%b, required 0 run=0", actual(), running);
      end
      do_step(OP_MOV_A_IM, SEL_ZERO, LD_A, 4'h5);
      #2;
      rst_n = 1'b0;
      #1;
      m = '0;
      checks++;
      if (actual() !== arch_t'(0)) begin
         errors++;
         $display("FAIL reset_async: got %h, required 0", actual());
      end
      checks++;
      if (running !== 1'b0 || exec_pulse !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got run=%b exec=%b, required 0 0", running, exec_pulse);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      // Reset in the middle of a divided RUN period.
      queue_instr(OP_JMP, SEL_ZERO, LD_PC, 4'h7, 0);
      run_en = 1'b1;
      observe(3, 1'b0, p);
      checks++;
      if (p !== 0 || running !== 1'b1) begin
         errors++;
         $display("FAIL reset_midrun_pre: got pulses=%0d run=%b, required 0 1", p, running);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (running !== 1'b0 || bus.pc !== 4'h0) begin
         errors++;
         $display("FAIL reset_midrun: got run=%b pc=%h, required 0 0", running, bus.pc);
      end
      run_en = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check_drained("reset");
   endtask

   task automatic test_add_carry();
      do_step(OP_MOV_A_IM, SEL_ZERO, LD_A, 4'hC);
      do_step(OP_ADD_A_IM, SEL_A, LD_A, 4'h6);
      checks++;
      if (dut.a_q !== 4'h2 || bus.c !== 1'b1) begin
         errors++;
         $display("FAIL add_carry: got a=%h c=%b, required a=2 c=1", dut.a_q, bus.c);
      end
      do_step(OP_ADD_A_IM, SEL_A, LD_A, 4'h0);
      check_drained("add_carry");
   endtask

   task automatic test_pc_wrap_jump();
      do_step(OP_JMP, SEL_ZERO, LD_PC, 4'hF);
      do_step(OP_OUT_IM, SEL_ZERO, LD_NONE, 4'h0);
      checks++;
      if (bus.pc !== 4'h0) begin
         errors++;
         $display("FAIL pc_wrap: got pc=%h, required 0", bus.pc);
      end
      do_step(OP_JMP, SEL_ZERO, LD_PC, 4'h9);
      check_drained("pc_jump");
   endtask

   task automatic test_in_out();
      in_port = 4'hA;
      do_step(OP_IN_B, SEL_IN, LD_B, 4'h1);
      do_step(OP_OUT_B, SEL_B, LD_OUT, 4'h0);
      checks++;
      if (out_port !== 4'hB || bus.op !== OP_OUT_B) begin
         errors++;
         $display("FAIL in_out: got out=%h op=%h, required out=b op=9", out_port, bus.op);
      end
      check_drained("in_out");
   endtask

   task automatic test_divider();
      int         p;
      logic [3:0] pc_exp;
      pc_exp = m.pc + 4'd3;
      queue_instr(OP_ADD_A_IM, SEL_A, LD_NONE, 4'hF, 3);
      run_en = 1'b1;
      observe(13, 1'b0, p);
      checks++;
      if (p !== 3 || bus.pc !== pc_exp) begin
         errors++;
         $display("FAIL divider_rate: got pulses=%0d pc=%h, required 3 pc=%h", p, bus.pc, pc_exp);
      end
      // Two more cycles puts the divider at 2, then drop run_en.
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      run_en = 1'b0;
      observe(8, 1'b0, p);
      checks++;
      if (p !== 0 || running !== 1'b0) begin
         errors++;
         $display("FAIL divider_halt: got pulses=%0d run=%b, required 0 0", p, running);
      end
      check_drained("divider");
   endtask

   task automatic test_step_hold();
      int p1;
      int p2;
      queue_instr(OP_ADD_B_IM, SEL_B, LD_B, 4'h3, 1);
      step = 1'b1;
      observe(5, 1'b0, p1);
      step = 1'b0;
      observe(3, 1'b0, p2);
      checks++;
      if (p1 + p2 !== 1) begin
         errors++;
         $display("FAIL step_hold: got %0d commits, required 1", p1 + p2);
      end
      check_drained("step_hold");
   endtask

   task automatic test_back_to_back();
      int p;
      queue_instr(OP_ADD_B_IM, SEL_B, LD_B, 4'h1, 3);
      run_en = 1'b1;
      step   = 1'b1;
      observe(13, 1'b1, p);
      run_en = 1'b0;
      step   = 1'b0;
      checks++;
      if (p !== 3) begin
         errors++;
         $display("FAIL step_in_run: got %0d commits, required 3", p);
      end
      observe(3, 1'b0, p);
      checks++;
      if (p !== 0) begin
         errors++;
         $display("FAIL step_in_run_tail: got %0d commits, required 0", p);
      end
      check_drained("back_to_back");
   endtask

   initial begin
      m            = '0;
      bus.rom_data = 8'h00;
      bus.sel      = SEL_ZERO;
      bus.ld       = LD_NONE;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      test_reset();
      test_add_carry();
      test_pc_wrap_jump();
      test_in_out();
      test_divider();
      test_step_hold();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
